uart_vitals_rx: RTL and testbench
=================================

// Module: uart_vitals_rx
// PURPOSE
//  UART receiver, the far-end counterpart of the vitals UART transmitter. Deserialises 8N1 frames
//  from data_rx and reassembles the 4-byte vitals packet {HR[7:0], HR[15:8], SpO2, 8'h0A}.
//  Presents heart_rate/spo2 with a one-cycle pkt_valid strobe; flags framing/packet errors.
//  Sits on the monitoring side between the RX pin and the cold-storage/vitals logic.
// PARAMETERS
//  CLKS_PER_BIT   434  clk cycles per UART bit (50 MHz / 115200); legal range 4..65535
//  TIMEOUT_BITS   20   max idle gap, in bit times, between bytes of one packet before resync
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst         in   1   synchronous reset, active-high
//  data_rx     in   1   UART RX line, async, idle high
//  heart_rate  out  16  last valid heart rate (little-endian reassembly)
//  spo2        out  8   last valid SpO2
//  pkt_valid   out  1   1-cycle pulse: heart_rate/spo2 updated this cycle
//  frame_err   out  1   1-cycle pulse: stop bit sampled low (or parity fail, see CONFIGURATION)
//  pkt_err     out  1   1-cycle pulse: 4th byte != 8'h0A, or inter-byte timeout mid-packet
//  rx_busy     out  1   high while bit FSM is outside IDLE
// BEHAVIOUR
//  - Reset: all outputs 0; bit FSM IDLE; byte index 0; sync FFs loaded with 1 (idle).
//  - data_rx passes a 2-FF synchroniser; all decisions use the synchronised value.
//  - Bit FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//    IDLE: falling edge (sync 1->0) starts START with bit counter cleared.
//    START: sample at CLKS_PER_BIT/2 (integer div); line high = false start -> IDLE, no flags.
//    DATA: 8 samples, every CLKS_PER_BIT clks after start-mid, LSB first into shift reg.
//    STOP: sample at mid-bit; high = byte good, low = frame_err pulse, byte discarded.
//    Return to IDLE right after stop-mid sample so back-to-back frames are received.
//  - Packet assembler (byte index 0..3, 2-bit, advances only on good bytes):
//    idx0 -> hr_lo, idx1 -> hr_hi, idx2 -> spo2_tmp, idx3 -> check terminator.
//    idx3 == 8'h0A: heart_rate<= {hr_hi,hr_lo}, spo2<=spo2_tmp, pkt_valid pulse, idx<=0.
//    idx3 != 8'h0A: pkt_err pulse, outputs unchanged, idx<=0.
//  - Latency: pkt_valid/pkt_err/frame_err assert the cycle after the relevant stop-mid sample.
//  - frame_err always forces idx<=0 (packet abandoned); no pkt_err in that case.
//  - Timeout: idx!=0 and FSM IDLE for TIMEOUT_BITS*CLKS_PER_BIT clks -> pkt_err pulse, idx<=0.
//    Timer clears on every start detection; never runs while idx==0.
//  - heart_rate/spo2 hold last valid packet; never partially updated.
//  - rst mid-frame: immediate abandon, all state to reset values; next falling edge restarts.
//  - Break (line held low): one frame_err, then FSM waits in IDLE for a new 1->0 edge.
//  - Error pulses are mutually exclusive with pkt_valid in any cycle.
// CONFIGURATION
//  UART_VITALS_RX_PARITY_EN defined: frame is 8E1; PARITY state between DATA and STOP samples
//    even parity; mismatch -> frame_err pulse after stop sample, byte discarded, idx<=0.
//  Undefined: 8N1 as above, no PARITY state, no parity logic synthesised.
// TESTING  (CLKS_PER_BIT=16, TIMEOUT_BITS=20 unless noted)
//  1. Send 8'h48,8'h00,8'h61,8'h0A back-to-back -> one pkt_valid, heart_rate=16'h0048, spo2=8'h61.
//  2. Send 8'h2C,8'h01,8'h5F,8'h0B -> pkt_err pulse, no pkt_valid, outputs keep test-1 values.
//  3. Stop bit of byte 2 driven low, then full good packet 8'h50,8'h00,8'h62,8'h0A
//     -> one frame_err, then pkt_valid with heart_rate=16'h0050, spo2=8'h62.
//  4. 4-clk low glitch on idle line -> no flags, rx_busy returns low at START mid-sample.
//  5. Send 8'h48,8'h00 then idle 21 bit times -> pkt_err pulse; next good packet decoded.
//  6. Assert rst during DATA of byte 1 -> outputs 0, rx_busy 0; following packet decodes OK.
//  7. With UART_VITALS_RX_PARITY_EN: byte with wrong parity -> frame_err, packet discarded.

Source files
------------

// File: rtl/uart_vitals_rx.sv
// UART receiver for the 4-byte vitals packet {HR lo, HR hi, SpO2, 8'h0A}; 8N1 by default.
// Define UART_VITALS_RX_PARITY_EN to receive 8E1 frames with even-parity checking.
module uart_vitals_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_rx,
  output logic [15:0] heart_rate,
  output logic [7:0]  spo2,
  output logic        pkt_valid,
  output logic        frame_err,
  output logic        pkt_err,
  output logic        rx_busy
);

  localparam logic [15:0]      HALF_C     = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0]      LAST_C     = 16'(CLKS_PER_BIT - 1);
  localparam int               TMO_LIMIT  = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int               TMO_W      = $clog2(TMO_LIMIT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST_C = TMO_W'(TMO_LIMIT - 1);
  localparam logic [TMO_W-1:0] TMO_ONE_C  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_ZERO_C = TMO_W'(0);
  localparam logic [7:0]       TERM_C     = 8'h0A;

`ifdef UART_VITALS_RX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity_err(input logic [7:0] data, input logic par_bit);
    return ^{data, par_bit};
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3
  } state_t;
`endif

  logic        sync1_q, sync2_q, rx_prev_q;
  logic        rx_s, fall_s;
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        busy_q;
  logic        byte_ok_s, byte_bad_s, start_det_s, par_fail_s;

  logic [1:0]       idx_q, idx_d;
  logic [7:0]       hr_lo_q, hr_lo_d, hr_hi_q, hr_hi_d, spo2_tmp_q, spo2_tmp_d;
  logic [15:0]      heart_rate_q, heart_rate_d;
  logic [7:0]       spo2_q, spo2_d;
  logic             pkt_valid_q, pkt_valid_d;
  logic             pkt_err_q, pkt_err_d;
  logic             frame_err_q, frame_err_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeout_s;

  assign rx_s   = sync2_q;
  assign fall_s = rx_prev_q & ~sync2_q;

`ifdef UART_VITALS_RX_PARITY_EN
  logic par_err_q, par_err_d;
  assign par_fail_s = par_err_q;
`else
  assign par_fail_s = 1'b0;
`endif

  // Two-flop synchroniser plus one history flop for start-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      sync1_q   <= data_rx;
      sync2_q   <= sync1_q;
      rx_prev_q <= sync2_q;
    end
  end

  // Bit FSM next-state: all sampling is relative to the start-bit midpoint.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_ok_s   = 1'b0;
    byte_bad_s  = 1'b0;
    start_det_s = 1'b0;
`ifdef UART_VITALS_RX_PARITY_EN
    par_err_d   = par_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (fall_s) begin
          state_d     = ST_START;
          start_det_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
        cnt_d = 16'd0;
      end
      ST_START: begin
        if (cnt_q == HALF_C) begin
          cnt_d = 16'd0;
          bit_d = 3'd0;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == LAST_C) begin
          cnt_d   = 16'd0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_VITALS_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`ifdef UART_VITALS_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == LAST_C) begin
          cnt_d     = 16'd0;
          par_err_d = even_parity_err(shift_q, rx_s);
          state_d   = ST_STOP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
`endif
      ST_STOP: begin
        // Back to IDLE at the stop midpoint so a following start edge is not missed.
        if (cnt_q == LAST_C) begin
          cnt_d   = 16'd0;
          state_d = ST_IDLE;
          if (rx_s && !par_fail_s) begin
            byte_ok_s = 1'b1;
          end else begin
            byte_bad_s = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 16'd0;
      end
    endcase
  end

  // Bit FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 16'd0;
      bit_q     <= 3'd0;
      shift_q   <= 8'd0;
      busy_q    <= 1'b0;
`ifdef UART_VITALS_RX_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      busy_q    <= (state_d != ST_IDLE);
`ifdef UART_VITALS_RX_PARITY_EN
      par_err_q <= par_err_d;
`endif
    end
  end

  assign timeout_s = (idx_q != 2'd0) && !start_det_s && (state_q == ST_IDLE) &&
                     (tmo_q == TMO_LAST_C);

  // Packet assembler and inter-byte timeout; outputs only move on a complete packet.
  always_comb begin
    idx_d        = idx_q;
    hr_lo_d      = hr_lo_q;
    hr_hi_d      = hr_hi_q;
    spo2_tmp_d   = spo2_tmp_q;
    heart_rate_d = heart_rate_q;
    spo2_d       = spo2_q;
    pkt_valid_d  = 1'b0;
    pkt_err_d    = 1'b0;
    frame_err_d  = 1'b0;
    tmo_d        = tmo_q;

    if (byte_bad_s) begin
      frame_err_d = 1'b1;
      idx_d       = 2'd0;
    end else if (byte_ok_s) begin
      case (idx_q)
        2'd0: begin
          hr_lo_d = shift_q;
          idx_d   = 2'd1;
        end
        2'd1: begin
          hr_hi_d = shift_q;
          idx_d   = 2'd2;
        end
        2'd2: begin
          spo2_tmp_d = shift_q;
          idx_d      = 2'd3;
        end
        2'd3: begin
          if (shift_q == TERM_C) begin
            heart_rate_d = {hr_hi_q, hr_lo_q};
            spo2_d       = spo2_tmp_q;
            pkt_valid_d  = 1'b1;
          end else begin
            pkt_err_d = 1'b1;
          end
          idx_d = 2'd0;
        end
        default: begin
          idx_d = 2'd0;
        end
      endcase
    end else if (timeout_s) begin
      pkt_err_d = 1'b1;
      idx_d     = 2'd0;
    end else begin
      idx_d = idx_q;
    end

    if ((idx_q == 2'd0) || start_det_s || timeout_s) begin
      tmo_d = TMO_ZERO_C;
    end else if (state_q == ST_IDLE) begin
      tmo_d = tmo_q + TMO_ONE_C;
    end else begin
      tmo_d = tmo_q;
    end
  end

  // Packet assembler registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= 2'd0;
      hr_lo_q      <= 8'd0;
      hr_hi_q      <= 8'd0;
      spo2_tmp_q   <= 8'd0;
      heart_rate_q <= 16'd0;
      spo2_q       <= 8'd0;
      pkt_valid_q  <= 1'b0;
      pkt_err_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      tmo_q        <= TMO_ZERO_C;
    end else begin
      idx_q        <= idx_d;
      hr_lo_q      <= hr_lo_d;
      hr_hi_q      <= hr_hi_d;
      spo2_tmp_q   <= spo2_tmp_d;
      heart_rate_q <= heart_rate_d;
      spo2_q       <= spo2_d;
      pkt_valid_q  <= pkt_valid_d;
      pkt_err_q    <= pkt_err_d;
      frame_err_q  <= frame_err_d;
      tmo_q        <= tmo_d;
    end
  end

  assign heart_rate = heart_rate_q;
  assign spo2       = spo2_q;
  assign pkt_valid  = pkt_valid_q;
  assign pkt_err    = pkt_err_q;
  assign frame_err  = frame_err_q;
  assign rx_busy    = busy_q;

endmodule

// File: tb/tb_uart_vitals_rx.sv
// Self-checking bench for uart_vitals_rx: directed scenarios plus randomized packet traffic
// compared against a byte-level packet model. Honours UART_VITALS_RX_PARITY_EN.
module tb_uart_vitals_rx;
  localparam int CPB = 16;
  localparam int TOB = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_rx;
  logic [15:0] heart_rate;
  logic [7:0]  spo2;
  logic        pkt_valid, frame_err, pkt_err, rx_busy;

  uart_vitals_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst(rst), .data_rx(data_rx),
    .heart_rate(heart_rate), .spo2(spo2),
    .pkt_valid(pkt_valid), .frame_err(frame_err), .pkt_err(pkt_err), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Event encoding: {kind, heart_rate, spo2}; kind 1 valid, 2 pkt_err, 3 frame_err, 4 overlap.
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];
  int          n_pulse;

  always @(negedge clk) begin
    if (!rst) begin
      n_pulse = int'(pkt_valid) + int'(pkt_err) + int'(frame_err);
      if (n_pulse > 1)     obs_q.push_back({8'd4, 24'd0});
      else if (pkt_valid)  obs_q.push_back({8'd1, heart_rate, spo2});
      else if (pkt_err)    obs_q.push_back({8'd2, 24'd0});
      else if (frame_err)  obs_q.push_back({8'd3, 24'd0});
    end
  end

  // Reference model: packet rules at byte granularity.
  int          m_idx;
  logic [7:0]  m_buf [3];
  logic [15:0] m_hr;
  logic [7:0]  m_spo2;

  task automatic model_reset();
    m_idx  = 0;
    m_hr   = 16'd0;
    m_spo2 = 8'd0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (!good) begin
      exp_q.push_back({8'd3, 24'd0});
      m_idx = 0;
    end else if (m_idx < 3) begin
      m_buf[m_idx] = b;
      m_idx++;
    end else begin
      if (b == 8'h0A) begin
        m_hr   = {m_buf[1], m_buf[0]};
        m_spo2 = m_buf[2];
        exp_q.push_back({8'd1, m_hr, m_spo2});
      end else begin
        exp_q.push_back({8'd2, 24'd0});
      end
      m_idx = 0;
    end
  endtask

  task automatic model_gap(input int bits);
    if (bits > TOB && m_idx != 0) begin
      exp_q.push_back({8'd2, 24'd0});
      m_idx = 0;
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic tx_byte(input logic [7:0] b, input bit stop_ok, input bit par_bad);
    data_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      data_rx = b[i];
      wait_clks(CPB);
    end
`ifdef UART_VITALS_RX_PARITY_EN
    data_rx = (^b) ^ par_bad;
    wait_clks(CPB);
    model_byte(b, stop_ok && !par_bad);
`else
    model_byte(b, stop_ok);
`endif
    data_rx = stop_ok;
    wait_clks(CPB);
    data_rx = 1'b1;
  endtask

  task automatic tx_gap(input int bits, input bit glitch);
    if (glitch && bits >= 3) begin
      wait_clks(CPB);
      data_rx = 1'b0;
      wait_clks(4);
      data_rx = 1'b1;
      wait_clks(bits * CPB - CPB - 4);
    end else begin
      wait_clks(bits * CPB);
    end
    model_gap(bits);
  endtask

  task automatic tx_packet(input logic [15:0] hr, input logic [7:0] sp, input logic [7:0] term);
    tx_byte(hr[7:0], 1'b1, 1'b0);
    tx_byte(hr[15:8], 1'b1, 1'b0);
    tx_byte(sp, 1'b1, 1'b0);
    tx_byte(term, 1'b1, 1'b0);
  endtask

  task automatic compare_events(input string tag);
    check_val({tag, "_nev"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      check_val({tag, "_ev"}, obs_q[i], exp_q[i]);
    check_val({tag, "_hr"}, {16'd0, heart_rate}, {16'd0, m_hr});
    check_val({tag, "_spo2"}, {24'd0, spo2}, {24'd0, m_spo2});
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    bit         ok, pbad, gl;
    int         g;
    logic [7:0] pk [4];

    rst = 1'b1;
    data_rx = 1'b1;
    model_reset();
    wait_clks(5);
    check_val("reset_out", {10'd0, heart_rate, spo2, pkt_valid, frame_err, pkt_err, rx_busy}, 32'd0);
    rst = 1'b0;
    wait_clks(5);

    // Good packet back-to-back.
    tx_packet(16'h0048, 8'h61, 8'h0A);
    tx_gap(25, 1'b0);
    check_val("t1_hr_const", {16'd0, heart_rate}, 32'h0000_0048);
    compare_events("t1");

    // Bad terminator keeps old values.
    tx_packet(16'h012C, 8'h5F, 8'h0B);
    tx_gap(25, 1'b0);
    check_val("t2_spo2_const", {24'd0, spo2}, 32'h0000_0061);
    compare_events("t2");

    // Stop bit low on a mid-packet byte, then a good packet.
    tx_byte(8'h11, 1'b1, 1'b0);
    tx_byte(8'h22, 1'b0, 1'b0);
    tx_gap(1, 1'b0);
    tx_packet(16'h0050, 8'h62, 8'h0A);
    tx_gap(25, 1'b0);
    compare_events("t3");

    // Short glitch on idle line is a false start.
    data_rx = 1'b0;
    wait_clks(4);
    data_rx = 1'b1;
    wait_clks(2);
    check_val("t4_busy_hi", {31'd0, rx_busy}, 32'd1);
    wait_clks(8);
    check_val("t4_busy_lo", {31'd0, rx_busy}, 32'd0);
    wait_clks(30);
    compare_events("t4");

    // Inter-byte timeout mid-packet.
    tx_byte(8'h48, 1'b1, 1'b0);
    tx_byte(8'h00, 1'b1, 1'b0);
    tx_gap(21, 1'b0);
    tx_packet(16'h3412, 8'h56, 8'h0A);
    tx_gap(25, 1'b0);
    compare_events("t5");

    // Reset in the middle of the second byte's data bits.
    tx_byte(8'h77, 1'b1, 1'b0);
    data_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 3; i++) begin
      data_rx = i[0];
      wait_clks(CPB);
    end
    rst = 1'b1;
    data_rx = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    model_reset();
    wait_clks(1);
    check_val("t6_after_rst", {10'd0, heart_rate, spo2, pkt_valid, frame_err, pkt_err, rx_busy}, 32'd0);
    tx_gap(2, 1'b0);
    tx_packet(16'h009A, 8'h5C, 8'h0A);
    tx_gap(25, 1'b0);
    compare_events("t6");

    // Line break: one frame error, no further activity until a new falling edge.
    data_rx = 1'b0;
    wait_clks(20 * CPB);
    exp_q.push_back({8'd3, 24'd0});
    m_idx = 0;
    data_rx = 1'b1;
    tx_gap(3, 1'b0);
    tx_packet(16'h0102, 8'h60, 8'h0A);
    tx_gap(25, 1'b0);
    compare_events("brk");

`ifdef UART_VITALS_RX_PARITY_EN
    // Wrong parity discards the packet.
    tx_byte(8'h48, 1'b1, 1'b0);
    tx_byte(8'h00, 1'b1, 1'b0);
    tx_byte(8'h61, 1'b1, 1'b1);
    tx_gap(1, 1'b0);
    tx_byte(8'h0A, 1'b1, 1'b0);
    tx_gap(25, 1'b0);
    compare_events("t7");
`endif

    // Randomized packet traffic with occasional errors, long gaps and glitches.
    for (int p = 0; p < 30; p++) begin
      pk[0] = 8'($urandom);
      pk[1] = 8'($urandom);
      pk[2] = 8'($urandom);
      pk[3] = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h0A;
      for (int k = 0; k < 4; k++) begin
        b    = pk[k];
        ok   = ($urandom_range(0, 19) != 0);
        pbad = 1'b0;
`ifdef UART_VITALS_RX_PARITY_EN
        pbad = ($urandom_range(0, 19) == 0);
`endif
        g = ($urandom_range(0, 19) < 17) ? int'($urandom_range(0, 4)) : 27;
        if ((!ok || pbad) && g == 0) g = 1;
        gl = (g >= 3) && ($urandom_range(0, 2) == 0);
        tx_byte(b, ok, pbad);
        tx_gap(g, gl);
      end
    end
    tx_gap(25, 1'b0);
    compare_events("rand");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
